// File: rtl/cache_req_sched_pkg.sv
// Shared types for the L1 front-end scheduler.
// Cache op encoding, scheduler states and requester ids.
package cache_req_sched_pkg;

  typedef enum logic [1:0] {
    NOP        = 2'd0,
    FETCH      = 2'd1,
    INVALIDATE = 2'd2,
    FILL       = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MREQ,
    S_FILL,
    S_RESP
  } sched_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Grant is combinational; only the last-grant bit is stored.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  // 1 = data port was granted last, so inst wins the next tie
  logic last;

  // Lone requester wins; on a tie pick the side not granted last
  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

  // Remember who won, only when the grant is actually consumed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last <= 1'b1;
    else if (take && |gnt) last <= gnt[1];
  end

endmodule

// File: rtl/cache_req_sched.sv
// L1 request scheduler: arbitrate inst/data, look up the
// array, fill the line on a miss, report and count.
module cache_req_sched
  import cache_req_sched_pkg::*;
#(
  parameter int ADDRBITS  = 32,
  parameter int LINEITEMS = 64,
  parameter int OFFBITS   = $clog2(LINEITEMS) + 2,
  parameter int CNTBITS   = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         inst_req,
  input  logic [ADDRBITS-1:0]          inst_addr,
  output logic                         inst_done,
  output logic                         inst_hit,
  input  logic                         data_req,
  input  logic [1:0]                   data_op,
  input  logic [ADDRBITS-1:0]          data_addr,
  output logic                         data_done,
  output logic                         data_hit,
  output logic [1:0]                   cache_op,
  output logic [ADDRBITS-1:0]          cache_addr,
  input  logic                         cache_ack,
  input  logic                         cache_hit,
  output logic                         fill_we,
  output logic [$clog2(LINEITEMS)-1:0] fill_idx,
  output logic                         mem_req,
  output logic [ADDRBITS-OFFBITS-1:0]  mem_addr,
  input  logic                         mem_ack,
  input  logic                         mem_beat,
  output logic                         busy,
  output logic [CNTBITS-1:0]           hits,
  output logic [CNTBITS-1:0]           misses
);

  localparam int IDXBITS = $clog2(LINEITEMS);
  localparam logic [IDXBITS-1:0] LAST_BEAT =
    IDXBITS'(LINEITEMS - 1);

  sched_state_t        state, state_n;
  op_t                 op_q;
  port_t               port_q;
  logic [ADDRBITS-1:0] addr_q;
  logic                hit_q;
  logic [IDXBITS-1:0]  cnt;
  logic [1:0]          gnt;
  logic                take;

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     ({data_req, inst_req}),
    .take    (take),
    .gnt     (gnt)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state and all per-state outputs
  always_comb begin
    state_n    = state;
    take       = 1'b0;
    cache_op   = NOP;
    cache_addr = '0;
    mem_req    = 1'b0;
    mem_addr   = '0;
    fill_we    = 1'b0;
    inst_done  = 1'b0;
    inst_hit   = 1'b0;
    data_done  = 1'b0;
    data_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          take    = 1'b1;
          state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        cache_op   = op_q;
        cache_addr = addr_q;
        if (cache_ack) begin
          if (op_q == INVALIDATE || cache_hit)
            state_n = S_RESP;
          else
            state_n = S_MREQ;
        end
      end
      S_MREQ: begin
        mem_req  = 1'b1;
        mem_addr = addr_q[ADDRBITS-1:OFFBITS];
        if (mem_ack) state_n = S_FILL;
      end
      S_FILL: begin
        cache_op   = FILL;
        cache_addr = addr_q;
        fill_we    = mem_beat;
        if (mem_beat && cnt == LAST_BEAT)
          state_n = S_RESP;
      end
      S_RESP: begin
        inst_done = (port_q == INST);
        inst_hit  = (port_q == INST) && hit_q;
        data_done = (port_q == DATA);
        data_hit  = (port_q == DATA) && hit_q;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign fill_idx = cnt;
  assign busy     = (state != S_IDLE);

  // Latch the granted request; later input changes are ignored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= NOP;
      port_q <= INST;
      addr_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      if (state == S_IDLE && take) begin
        port_q <= gnt[1] ? DATA : INST;
        addr_q <= gnt[1] ? data_addr : inst_addr;
        op_q   <= (gnt[1] && data_op == INVALIDATE)
                  ? INVALIDATE : FETCH;
      end
      if (state == S_LOOKUP && cache_ack) hit_q <= cache_hit;
    end
  end

  // Fill beat counter; wraps to 0 after the last beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (state == S_FILL && mem_beat) cnt <= cnt + 1'b1;
  end

  // Saturating hit/miss statistics for completed fetches
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hits   <= '0;
      misses <= '0;
    end else if (state == S_RESP && op_q != INVALIDATE) begin
      if (hit_q) begin
        if (hits != '1) hits <= hits + CNTBITS'(1);
      end else begin
        if (misses != '1) misses <= misses + CNTBITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_cache_req_sched.sv
// Directed bench for cache_req_sched with small
// cache/memory responders driven from the test process.
module tb_cache_req_sched;

  localparam logic [1:0] OP_FETCH = 2'd1;
  localparam logic [1:0] OP_INV   = 2'd2;
  localparam logic [1:0] OP_FILL  = 2'd3;

  logic        clock, reset_n;
  logic        inst_req, inst_done, inst_hit;
  logic [31:0] inst_addr;
  logic        data_req, data_done, data_hit;
  logic [1:0]  data_op;
  logic [31:0] data_addr;
  logic [1:0]  cache_op;
  logic [31:0] cache_addr;
  logic        cache_ack, cache_hit;
  logic        fill_we;
  logic [5:0]  fill_idx;
  logic        mem_req, mem_ack, mem_beat;
  logic [23:0] mem_addr;
  logic        busy;
  logic [3:0]  hits, misses;

  cache_req_sched #(
    .ADDRBITS(32), .LINEITEMS(64), .CNTBITS(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_done(inst_done), .inst_hit(inst_hit),
    .data_req(data_req), .data_op(data_op),
    .data_addr(data_addr), .data_done(data_done),
    .data_hit(data_hit), .cache_op(cache_op),
    .cache_addr(cache_addr), .cache_ack(cache_ack),
    .cache_hit(cache_hit), .fill_we(fill_we),
    .fill_idx(fill_idx), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_beat(mem_beat), .busy(busy),
    .hits(hits), .misses(misses)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // responder knobs
  bit chit_knob;
  int mem_wait;
  int gap_at;
  bit gap_done;
  bit stray;

  // monitors
  int          cyc = 0;
  int          mreq_cycles, n_fill, idx_err, beats;
  int          inst_dn, data_dn, done_at, dbl, ngr;
  bit          mem_seen, prev_done;
  logic [23:0] mem_addr_seen;
  logic        done_hit;
  logic [1:0]  lk_op;
  logic [31:0] lk_addr;
  logic [3:0]  gbits;
  int          start;

  typedef struct {
    bit          is_data;
    logic [1:0]  op;
    logic [31:0] addr;
    bit          chit;
    bit          exp_hit;
    logic [3:0]  exp_hits;
    logic [3:0]  exp_misses;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic clear_mon();
    mreq_cycles = 0; n_fill = 0; idx_err = 0; beats = 0;
    inst_dn = 0; data_dn = 0; done_at = -1; dbl = 0;
    ngr = 0; mem_seen = 0; prev_done = 0;
    mem_addr_seen = '0; done_hit = 0; lk_op = '0;
    lk_addr = '0; gbits = '0; gap_done = 0;
  endtask

  // One cycle: respond at negedge, then sample outputs.
  task automatic tick();
    @(negedge clock);
    cyc++;
    cache_ack = (cache_op == OP_FETCH) || (cache_op == OP_INV);
    cache_hit = cache_ack && chit_knob;
    if (cache_ack) begin
      lk_op   = cache_op;
      lk_addr = cache_addr;
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      mem_seen      = 1;
      mem_addr_seen = mem_addr;
      mem_ack       = (mreq_cycles >= mem_wait);
      mreq_cycles++;
    end
    mem_beat = stray;
    if (cache_op == OP_FILL) begin
      if (beats == gap_at && !gap_done) begin
        gap_done = 1;
        mem_beat = 1'b0;
      end else begin
        mem_beat = 1'b1;
      end
    end
    #1;
    if (cache_op == OP_FILL && mem_beat) beats++;
    if (fill_we) begin
      if (fill_idx != 6'(n_fill)) idx_err++;
      n_fill++;
    end
    if (inst_done) inst_dn++;
    if (data_done) data_dn++;
    if (inst_done || data_done) begin
      if (prev_done) dbl++;
      done_at  = cyc;
      done_hit = inst_done ? inst_hit : data_hit;
      gbits    = {gbits[2:0], data_done};
      ngr++;
    end
    prev_done = inst_done || data_done;
  endtask

  task automatic do_txn(input bit is_data,
                        input logic [1:0] op,
                        input logic [31:0] addr,
                        input bit chit,
                        input int wait_c,
                        input int gapat,
                        input bit scramble);
    clear_mon();
    chit_knob = chit;
    mem_wait  = wait_c;
    gap_at    = gapat;
    start     = cyc;
    if (is_data) begin
      data_req = 1; data_op = op; data_addr = addr;
    end else begin
      inst_req = 1; inst_addr = addr;
    end
    for (int i = 0; i < 300 && ngr == 0; i++) begin
      tick();
      if (scramble) begin
        data_addr = 32'hDEAD_BEEF;
        inst_addr = 32'hDEAD_BEEF;
        data_op   = OP_INV;
      end
    end
    chk("done_seen", 32'(ngr), 32'd1);
    inst_req = 0;
    data_req = 0;
    tick();
    tick();
  endtask

  initial begin
    vecs[0] = '{0, OP_FETCH, 32'h0000_1040, 1, 1, 4'd1, 4'd0};
    vecs[1] = '{1, OP_INV,   32'h0000_3000, 1, 1, 4'd1, 4'd0};
    vecs[2] = '{1, OP_INV,   32'h0000_3040, 0, 0, 4'd1, 4'd0};
    vecs[3] = '{1, OP_FETCH, 32'h0000_2100, 1, 1, 4'd2, 4'd0};
    vecs[4] = '{0, OP_FETCH, 32'h0000_0ABC, 1, 1, 4'd3, 4'd0};

    reset_n = 0;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_op = OP_FETCH; data_addr = '0;
    cache_ack = 0; cache_hit = 0;
    mem_ack = 0; mem_beat = 0;
    chit_knob = 0; mem_wait = 0; gap_at = -1; stray = 0;
    clear_mon();
    repeat (3) @(negedge clock);
    chk("reset_outs",
        {busy, cache_op, mem_req, fill_we, inst_done,
         inst_hit, data_done, data_hit, fill_idx,
         |cache_addr, |mem_addr}, 32'd0);
    chk("reset_hits", 32'(hits), 32'd0);
    chk("reset_misses", 32'(misses), 32'd0);
    #1 reset_n = 1;

    // hits and invalidates through the table
    for (int v = 0; v < 5; v++) begin
      do_txn(vecs[v].is_data, vecs[v].op, vecs[v].addr,
             vecs[v].chit, 0, -1, 0);
      chk($sformatf("v%0d_hit", v), 32'(done_hit),
          32'(vecs[v].exp_hit));
      chk($sformatf("v%0d_latency", v),
          32'(done_at - start), 32'd2);
      chk($sformatf("v%0d_port", v),
          32'(vecs[v].is_data ? data_dn : inst_dn), 32'd1);
      chk($sformatf("v%0d_otherport", v),
          32'(vecs[v].is_data ? inst_dn : data_dn), 32'd0);
      chk($sformatf("v%0d_cache_op", v), 32'(lk_op),
          32'(vecs[v].op));
      chk($sformatf("v%0d_cache_addr", v), lk_addr,
          vecs[v].addr);
      chk($sformatf("v%0d_no_mem_req", v), 32'(mem_seen), 32'd0);
      chk($sformatf("v%0d_hits", v), 32'(hits),
          32'(vecs[v].exp_hits));
      chk($sformatf("v%0d_misses", v), 32'(misses),
          32'(vecs[v].exp_misses));
      chk($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
    end

    // miss with ack wait 3, gap after beat 31, stray beats,
    // and the requester scribbling on addr/op mid-flight
    stray = 1;
    do_txn(1, OP_FETCH, 32'h0000_2000, 0, 3, 32, 1);
    stray = 0;
    chk("miss_mem_addr", 32'(mem_addr_seen), 32'h20);
    chk("miss_fill_we", 32'(n_fill), 32'd64);
    chk("miss_fill_idx_err", 32'(idx_err), 32'd0);
    chk("miss_hit", 32'(done_hit), 32'd0);
    chk("miss_data_done", 32'(data_dn), 32'd1);
    chk("miss_latency", 32'(done_at - start), 32'd71);
    chk("miss_misses", 32'(misses), 32'd1);
    chk("miss_hits", 32'(hits), 32'd3);
    chk("miss_lookup_addr", lk_addr, 32'h0000_2000);
    chk("miss_single_pulse", 32'(dbl), 32'd0);

    // both ports held for four hits: strict alternation
    clear_mon();
    chit_knob = 1;
    inst_addr = 32'h100; data_addr = 32'h200;
    data_op = OP_FETCH;
    inst_req = 1; data_req = 1;
    start = cyc;
    for (int i = 0; i < 100 && ngr < 4; i++) tick();
    inst_req = 0; data_req = 0;
    tick(); tick();
    chk("rr_count", 32'(ngr), 32'd4);
    chk("rr_order", 32'(gbits), 32'b0101);
    chk("rr_single_pulse", 32'(dbl), 32'd0);
    chk("rr_last_done", 32'(done_at - start), 32'd11);
    chk("rr_hits", 32'(hits), 32'd7);

    // saturate the 4-bit hit counter
    for (int i = 0; i < 8; i++)
      do_txn(0, OP_FETCH, 32'h40 * i, 1, 0, -1, 0);
    chk("sat_reach", 32'(hits), 32'd15);
    do_txn(0, OP_FETCH, 32'h0000_5000, 1, 0, -1, 0);
    chk("sat_hold", 32'(hits), 32'd15);
    chk("sat_misses", 32'(misses), 32'd1);

    // reset in the middle of a fill
    clear_mon();
    chit_knob = 0; mem_wait = 0; gap_at = -1;
    inst_addr = 32'h0000_4000;
    inst_req = 1;
    for (int i = 0; i < 100 && n_fill < 10; i++) tick();
    chk("rst_fill_progress", 32'(n_fill), 32'd10);
    #2 reset_n = 0;
    #1;
    chk("rst_async_outs",
        {busy, cache_op, mem_req, fill_we, inst_done,
         data_done, fill_idx}, 32'd0);
    chk("rst_async_cnt", {hits, misses}, 32'd0);
    inst_req = 0;
    tick(); tick();
    reset_n = 1;
    repeat (4) tick();
    chk("rst_no_done", 32'(inst_dn + data_dn), 32'd0);
    chk("rst_no_more_fill", 32'(n_fill), 32'd10);
    chk("rst_idle", 32'(busy), 32'd0);

    // after reset the pointer favours inst
    clear_mon();
    chit_knob = 1;
    data_op = OP_FETCH;
    inst_req = 1; data_req = 1;
    for (int i = 0; i < 50 && ngr < 2; i++) tick();
    inst_req = 0; data_req = 0;
    tick(); tick();
    chk("rst_rr_order", 32'(gbits[1:0]), 32'b01);
    chk("rst_rr_hits", 32'(hits), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
